uart_tx_fsm: RTL and testbench

UART transmitter, 8N1 by default: accepts a parallel word on a start strobe and serialises it LSB-first on `tx` with one start bit and one stop bit. It is the transmit-side counterpart of `uart_rx_fsm`, with the same `FREQ`/`F_SIZE` parameterisation and bit timing, so the two ends can be looped back on one board or one bench.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fsm_if.sv | 28 ++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_tx_fsm.sv | 102 ++++++++++
 tb/tb_uart_tx_fsm.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, bit-timing helper and default frame size.
// Used by both the receive and transmit FSMs so their timing always agrees.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_F_SIZE = 8;

    // Integer division: any remainder is absorbed as a small baud-rate error.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Parallel-side bundle of the UART transmitter: start request and word in, line and status out.
interface uart_tx_fsm_if #(
    parameter int F_SIZE = 8
);
    // Handshake: tx_start acts as valid and ~busy as ready; a word is taken on any rising edge
    // where tx_start=1 and busy=0. A request made while busy=1 is dropped, never held over.
    logic              tx_start;
    logic [F_SIZE-1:0] tx_data;
    logic              tx;
    logic              busy;
    logic              end_o;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  busy,
        input  end_o
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output busy,
        output end_o
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high for one cycle every CLKS_PER_BIT cycles, phase-aligned by clr.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter (8N1 by default): serialises tx_data LSB-first between a start and a stop bit.
// Bit timing matches uart_rx_fsm so the two can be looped back directly.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int FREQ   = 1000000,
    parameter int BAUD   = 20000,
    parameter int F_SIZE = UART_F_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_fsm_if.slave bus,
    output uart_state_t  state_dbg
);
    localparam int CLKS_PER_BIT = clks_per_bit(FREQ, BAUD);
    localparam int BW = $clog2(F_SIZE + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(F_SIZE - 1);

    if (CLKS_PER_BIT < 2 || F_SIZE < 1) begin : g_param_check
        $error("uart_tx_fsm: need CLKS_PER_BIT >= 2 and F_SIZE >= 1");
    end

    uart_state_t       state;
    logic [F_SIZE-1:0] shreg;
    logic [F_SIZE-1:0] shreg_next;
    logic [BW-1:0]     bit_cnt;
    logic              tx_q;
    logic              end_q;
    logic              accept;
    logic              tick;

    assign accept     = (state == IDLE) && bus.tx_start;
    assign shreg_next = shreg >> 1;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            end_q   <= 1'b0;
        end else begin
            end_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (accept) begin
                        state   <= START;
                        shreg   <= bus.tx_data;
                        bit_cnt <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        tx_q  <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= shreg_next;
                        bit_cnt <= bit_cnt + BW'(1);
                        // The tick that ends the last data bit opens the stop bit.
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            tx_q <= shreg_next[0];
                        end
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (tick) begin
                        state <= IDLE;
                        end_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx    = tx_q;
    assign bus.end_o = end_q;
    assign bus.busy  = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: stimulus pushes expected frames, a line monitor decodes tx and compares.
module tb_uart_tx_fsm;
    import uart_pkg::*;

    localparam int FREQ  = 1000000;
    localparam int BAUD  = 20000;
    localparam int F     = 8;
    localparam int CPB   = FREQ / BAUD;
    localparam int TOTAL = (F + 2) * CPB;
    localparam int W     = F + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    uart_tx_fsm_if #(.F_SIZE(F)) bus ();
    uart_state_t state_dbg;

    uart_tx_fsm #(
        .FREQ  (FREQ),
        .BAUD  (BAUD),
        .F_SIZE(F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    int next_ok      = 0;   // earliest edge at which the model accepts a new request
    int frames_exp   = 0;
    int frames_seen  = 0;
    int spurious_end = 0;
    int idle_busy    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic request(input logic [F-1:0] d);
        int e;
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        e = cyc + 1;
        if (!rst && e >= next_ok) begin
            exp_q.push_back({32'(e), d});
            next_ok = e + TOTAL + 1;
            frames_exp++;
        end
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
    endtask

    logic mon_active = 1'b0;
    logic expect_end = 1'b0;

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || mon_active || expect_end) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_in_time", 64'(t < 3000), 64'd1);
    endtask

    // ---------------- monitor: decodes the line against the expected frame ----------------
    int pos;
    int line_bad;
    int cur_edge;
    logic [F-1:0] cur_data;
    logic [F-1:0] got;

    always @(negedge clk) begin
        int phase;
        logic exp_lvl;
        if (rst) begin
            mon_active = 1'b0;
            expect_end = 1'b0;
        end else if (expect_end) begin
            check("end_o_pulse", 64'(bus.end_o), 64'd1);
            check("busy_in_end_cycle", 64'(bus.busy), 64'd0);
            expect_end = 1'b0;
        end else begin
            if (!mon_active) begin
                if (bus.tx === 1'b0) begin
                    check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        {cur_edge, cur_data} = exp_q.pop_front();
                    end else begin
                        cur_edge = cyc;
                        cur_data = '0;
                    end
                    check("start_edge", 64'(cyc), 64'(cur_edge));
                    mon_active = 1'b1;
                    pos        = 0;
                    line_bad   = 0;
                    got        = '0;
                end else begin
                    if (bus.end_o !== 1'b0) spurious_end++;
                    if (bus.busy !== 1'b0) idle_busy++;
                end
            end
            if (mon_active) begin
                phase = pos / CPB;
                if (phase == 0) exp_lvl = 1'b0;
                else if (phase <= F) exp_lvl = cur_data[phase-1];
                else exp_lvl = 1'b1;
                if (bus.tx !== exp_lvl || bus.busy !== 1'b1 || bus.end_o !== 1'b0) line_bad++;
                if (phase >= 1 && phase <= F && (pos % CPB) == CPB / 2) got[phase-1] = bus.tx;
                pos++;
                if (pos == TOTAL) begin
                    check("line_levels", 64'(line_bad), 64'd0);
                    check("word", 64'(got), 64'(cur_data));
                    mon_active = 1'b0;
                    expect_end = 1'b1;
                    frames_seen++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        idle(3);
        check("reset_tx", 64'(bus.tx), 64'd1);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_end_o", 64'(bus.end_o), 64'd0);
        check("reset_state", 64'(state_dbg), 64'(IDLE));

        // Reset held with a start request present: nothing may be accepted.
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            idle(2);
            check("rst_hold_tx", 64'(bus.tx), 64'd1);
            check("rst_hold_busy", 64'(bus.busy), 64'd0);
        end
        bus.tx_start = 1'b0;
        rst = 1'b0;
        idle(2);
        check("after_rst_idle", 64'(bus.busy), 64'd0);

        // Single frames with fixed patterns.
        request(8'hAA);
        drain();
        request(8'h00);
        drain();
        request(8'hFF);
        drain();

        // Back-to-back: second request lands in the end_o cycle of the first.
        request(8'h55);
        idle(TOTAL);
        request(8'hA3);
        drain();

        // Word changes and a second start during a frame must not disturb it.
        request(8'h3C);
        bus.tx_data = 8'hFF;
        idle(118);
        request(8'hFF);
        drain();

        // Reset partway through a frame abandons it.
        request(8'hC3);
        idle(229);
        rst = 1'b1;
        exp_q.delete();
        frames_exp--;
        next_ok = 0;
        idle(1);
        check("midrst_tx", 64'(bus.tx), 64'd1);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_end_o", 64'(bus.end_o), 64'd0);
        rst = 1'b0;
        idle(5);
        request(8'h81);
        drain();

        // Random words, gaps ranging from mid-frame (ignored) to exact back-to-back.
        for (int i = 0; i < 36; i++) begin
            case ($urandom_range(0, 3))
                0: idle(TOTAL);
                1: idle($urandom_range(1, TOTAL));
                default: idle($urandom_range(TOTAL, TOTAL + 20));
            endcase
            request(F'($urandom));
            bus.tx_data = F'($urandom);
        end
        drain();
        idle(4);

        check("frames_count", 64'(frames_seen), 64'(frames_exp));
        check("spurious_end_o", 64'(spurious_end), 64'd0);
        check("busy_while_idle", 64'(idle_busy), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
